// File: rtl/encoder42_sync.sv
// Synchronised, debounced 4:2 priority encoder for active-low request lines.
// Each accepted press is offered once over a valid/ack handshake.
module encoder42_sync #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] y_in,
  input  logic       ack,
  output logic       a,
  output logic       b,
  output logic       multi,
  output logic       valid
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HOLD,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [3:0]       y_m;
  logic [3:0]       y_s;
  logic             en_m;
  logic             en_s;
  logic [3:0]       cap;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic [1:0]       code;
  logic             many;
  logic             released;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_m  <= 4'b1111;
      y_s  <= 4'b1111;
      en_m <= 1'b1;
      en_s <= 1'b1;
    end else begin
      y_m  <= y_in;
      y_s  <= y_m;
      en_m <= en;
      en_s <= en_m;
    end
  end

  assign released = (y_s == 4'b1111);
  assign many     = ($countones(~cap) > 1);

  // Highest-numbered low line wins.
  always_comb begin
    code = 2'd0;
    priority case (1'b1)
      !cap[3]: code = 2'd3;
      !cap[2]: code = 2'd2;
      !cap[1]: code = 2'd1;
      default: code = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= 4'b1111;
      a     <= 1'b0;
      b     <= 1'b0;
      multi <= 1'b0;
      valid <= 1'b0;
    end else if (en_s) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!released) begin
            cap   <= y_s;
            cnt   <= ONE;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (released) begin
            state <= IDLE;
          end else if (y_s != cap) begin
            cap <= y_s;
            cnt <= ONE;
          end else if (cnt == LAST) begin
            {a, b} <= code;
            multi  <= many;
            valid  <= 1'b1;
            state  <= HOLD;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HOLD: begin
          if (valid && ack) begin
            valid <= 1'b0;
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!released) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder42_sync.sv
// Bench for encoder42_sync: directed plan steps plus random traffic,
// checked every edge against a run-length reference model.
module tb_encoder42_sync;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] y_in = 4'b1111;
  logic       ack = 1'b0;
  logic       a, b, multi, valid;

  int checks = 0;
  int failures = 0;

  encoder42_sync #(.STABLE_CYCLES(SC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .y_in(y_in),
    .ack(ack),
    .a(a),
    .b(b),
    .multi(multi),
    .valid(valid)
  );

  always #5 clk = ~clk;

  // Reference: pipeline of raw inputs plus run lengths of stable samples.
  logic [3:0] m_y1, m_y2, m_last;
  logic       m_e1, m_e2;
  bit         m_valid, m_hold, m_rel;
  int         m_run, m_rel_run;
  logic [1:0] m_code;
  bit         m_multi;

  task automatic model_reset();
    m_y1 = 4'hF; m_y2 = 4'hF; m_last = 4'hF;
    m_e1 = 1'b1; m_e2 = 1'b1;
    m_valid = 0; m_hold = 0; m_rel = 0;
    m_run = 0; m_rel_run = 0;
    m_code = 2'd0; m_multi = 0;
  endtask

  task automatic model_edge(input logic [3:0] yv, input logic ev,
                            input logic av);
    logic [3:0] s;
    int zeros;
    s = m_y2;
    if (m_e2) begin
      m_valid = 0; m_hold = 0; m_rel = 0; m_run = 0;
    end else if (m_hold) begin
      if (av) begin
        m_valid = 0; m_hold = 0; m_rel = 1; m_rel_run = 0;
      end
    end else if (m_rel) begin
      if (s == 4'hF) begin
        m_rel_run++;
        if (m_rel_run == SC) begin
          m_rel = 0; m_run = 0;
        end
      end else begin
        m_rel_run = 0;
      end
    end else begin
      if (s == 4'hF) m_run = 0;
      else if (m_run > 0 && s == m_last) m_run++;
      else begin
        m_run = 1; m_last = s;
      end
      if (m_run == SC) begin
        zeros = 0;
        for (int i = 0; i < 4; i++)
          if (!s[i]) begin
            m_code = 2'(i);
            zeros++;
          end
        m_multi = (zeros > 1);
        m_valid = 1; m_hold = 1; m_run = 0;
      end
    end
    m_y2 = m_y1; m_y1 = yv;
    m_e2 = m_e1; m_e1 = ev;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] yv;
    logic ev, av;
    yv = y_in; ev = en; av = ack;
    @(posedge clk);
    model_edge(yv, ev, av);
    #1;
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("code", {29'd0, a, b, multi}, {29'd0, m_code, m_multi});
  endtask

  task automatic press(input logic [3:0] p, input logic [1:0] ab,
                       input logic mu);
    int n;
    n = 0;
    y_in = p;
    while (valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("latency", n, SC + 2);
    chk("press_code", {29'd0, a, b, multi}, {29'd0, ab, mu});
  endtask

  task automatic idle(input int n);
    y_in = 4'hF;
    repeat (n) tick();
  endtask

  task automatic ack_release();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_drop", {31'd0, valid}, 32'd0);
    idle(8);
  endtask

  task automatic no_valid(input string tag, input logic [3:0] p0,
                          input logic [3:0] p1, input int n);
    bit seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      y_in = (i % 2 == 0) ? p0 : p1;
      tick();
      if (valid === 1'b1) seen = 1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    bit seen;
    int hold_n;
    model_reset();
    #2;
    chk("reset_out", {28'd0, a, b, multi, valid}, 32'd0);
    #10;
    rst_n = 1'b1;
    en = 1'b0;
    idle(6);

    // Single press, then asynchronous reset from a running state.
    press(4'b1011, 2'd2, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {28'd0, a, b, multi, valid}, 32'd0);
    model_reset();
    y_in = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid === 1'b1) seen = 1;
    end
    chk("post_reset_quiet", {31'd0, seen}, 32'd0);

    press(4'b1011, 2'd2, 1'b0);
    ack_release();
    press(4'b1110, 2'd0, 1'b0);
    ack_release();
    press(4'b1101, 2'd1, 1'b0);
    ack_release();
    press(4'b0111, 2'd3, 1'b0);
    ack_release();

    // Priority with several lines low.
    press(4'b0110, 2'd3, 1'b1);
    ack_release();
    press(4'b1100, 2'd1, 1'b1);
    ack_release();

    // Bounce rejection.
    no_valid("bounce_release", 4'b1110, 4'b1111, 12);
    press(4'b1101, 2'd1, 1'b0);
    ack_release();
    no_valid("bounce_swap", 4'b1110, 4'b1101, 12);
    idle(8);

    // One code per press; new code only after a debounced release.
    press(4'b1011, 2'd2, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_pulse", {31'd0, valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid === 1'b1) seen = 1;
    end
    chk("held_once", {31'd0, seen}, 32'd0);
    idle(6);
    press(4'b1110, 2'd0, 1'b0);
    ack_release();

    // Ack already high: valid lasts a single cycle.
    ack = 1'b1;
    press(4'b1101, 2'd1, 1'b0);
    tick();
    chk("ack_early", {31'd0, valid}, 32'd0);
    ack = 1'b0;
    idle(8);

    // Disable while holding a code.
    press(4'b1101, 2'd1, 1'b0);
    en = 1'b1;
    tick();
    tick();
    chk("dis_hold_2", {31'd0, valid}, 32'd1);
    tick();
    chk("dis_hold_3", {31'd0, valid}, 32'd0);
    chk("dis_keep", {29'd0, a, b, multi}, {29'd0, 2'd1, 1'b0});

    // Disable during debounce.
    y_in = 4'hF;
    en = 1'b0;
    repeat (4) tick();
    y_in = 4'b1011;
    repeat (3) tick();
    en = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid === 1'b1) seen = 1;
    end
    chk("dis_debounce", {31'd0, seen}, 32'd0);
    en = 1'b0;
    idle(6);
    press(4'b0111, 2'd3, 1'b0);
    ack_release();

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      y_in = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 15) == 0);
      hold_n = $urandom_range(1, 8);
      for (int j = 0; j < hold_n; j++) begin
        ack = ($urandom_range(0, 3) == 0);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
